adc_pot_spi_slave: RTL and testbench
====================================

Name: adc_pot_spi_slave

Overview:
- Behavioural/synthesizable model of the 8-channel, 12-bit SPI A2D converter wired to the equalizer's six slide potentiometers (LP, B1, B2, B3, HP, VOL).
- Answers the Equalizer's SPI master, a 16-bit-frame ADC128S-style protocol. Each transaction's command word selects the channel whose result is returned in the next transaction.
- Runs entirely in the clk domain; the SPI pins are synchronized and edge-detected.

Parameters:
- DATA_W, 12, conversion result width; pot inputs are DATA_W bits; the returned frame is zero-padded to 16 bits.
- SYNC_STG, 2, number of flop stages synchronizing SS_n, SCLK and MOSI into clk.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- SS_n, input, 1, SPI slave select, active low.
- SCLK, input, 1, SPI clock from master; idles high.
- MOSI, input, 1, command bits from master, MSB first.
- MISO, output, 1, result bits to master, MSB first.
- LP, input, 12, low-pass pot value (0..4095).
- B1, input, 12, band-1 pot value.
- B2, input, 12, band-2 pot value.
- B3, input, 12, band-3 pot value.
- HP, input, 12, high-pass pot value.
- VOL, input, 12, volume pot value.

Behaviour:
- Reset: sync flops cleared with SS_n/SCLK stages preset to 1 (idle); tx_shift = 0; rx_shift = 0; bit_cnt = 0; first_fall = 1; chnnl = 0; MISO = 0.
- Synchronize SS_n, SCLK and MOSI through SYNC_STG flops. Edge-detect on the last two stages: ss_fall, ss_rise, sclk_rise, sclk_fall. Edges are therefore acted on SYNC_STG+1 clk cycles after the pin transition. The master must hold SCLK half-periods of at least 4 clk.
- Channel map, fixed: ch0 = B1, ch1 = LP, ch2 = B3, ch3 = HP, ch4 = B2, ch7 = VOL. ch5 and ch6 return 12'h000.
- On ss_fall:
  - tx_shift <= {4'b0000, pot[chnnl]}; the pot value is sampled at this cycle.
  - bit_cnt <= 0; first_fall <= 1.
- While SS_n (synchronized) is low:
  - sclk_rise: rx_shift <= {rx_shift[14:0], MOSI_sync}; bit_cnt increments, saturating at 16.
  - sclk_fall with first_fall = 1: clear first_fall; no shift. The MSB stays valid for the first rising edge.
  - sclk_fall with first_fall = 0: tx_shift <= {tx_shift[14:0], 1'b0}.
- MISO = tx_shift[15] while synchronized SS_n is low, else 0. Registered, no combinational path from pins.
- On ss_rise with bit_cnt == 16: chnnl <= rx_shift[13:11] (bits 15:14 and 10:0 are don't-care).
- On ss_rise with bit_cnt < 16 (aborted frame): chnnl unchanged; return to idle.
- More than 16 rising edges in one frame: rx_shift keeps shifting; bit_cnt stays at 16; chnnl is taken from the last 16 bits.
- SCLK edges while SS_n is high are ignored.
- ss_fall and ss_rise are mutually exclusive by construction. An SCLK edge in the same cycle as ss_fall is ignored.
- Pot inputs changing mid-frame do not alter the frame already loaded.
- rst asserted mid-frame: all state returns to reset values immediately (next clk edge), chnnl = 0, MISO = 0. The master's current frame is lost.

Test Plan:
- Reset, then one full 16-bit frame with MOSI = 16'h0000, LP = 1028, B1 = 12'h123 -> MISO shifts out 16'h0123 (ch0 = B1). chnnl stays 0.
- Frame 1 MOSI = 16'h0800 (ch1), frame 2 any command -> frame 2 returns 16'h0404 (LP = 1028).
- Command ch7 with VOL = 1000, then a read frame -> 16'h03E8; VOL = 4095 -> 16'h0FFF. Upper nibble is always 0.
- Command ch5, then read -> 16'h0000 regardless of pot values.
- Abort: select ch3 (HP = 12'hABC), then frame with MOSI = ch4 raised after 8 SCLKs, then full frame -> returns 16'h0ABC (channel not updated by the aborted frame).
- Assert rst for one clk mid-frame after selecting ch7 -> MISO = 0 next cycle; the next full frame returns the ch0 (B1) value.

Source files
------------

// File: rtl/adc_pot_spi_slave.sv
// -----------------------------------------------------------------------------
// adc_pot_spi_slave
// Synthesizable model of the 8-channel 12-bit SPI A2D converter that digitizes
// the equalizer's six slide pots. Answers a 16-bit-frame ADC128S-style master:
// the command word of each frame selects the channel returned in the next one.
// Everything runs in the clk domain; the SPI pins are synchronized and
// edge-detected, so the master must hold SCLK half-periods >= 4 clk.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI  : SPI pins from the master (asynchronous to clk)
//   MISO              : registered result bit to the master, MSB first
//   LP,B1,B2,B3,HP,VOL: pot values, DATA_W bits each
// Channel map: ch0=B1 ch1=LP ch2=B3 ch3=HP ch4=B2 ch7=VOL, ch5/ch6 read 0.
// -----------------------------------------------------------------------------
module adc_pot_spi_slave #(
    parameter int DATA_W   = 12,
    parameter int SYNC_STG = 2     // must be >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] LP,
    input  logic [DATA_W-1:0] B1,
    input  logic [DATA_W-1:0] B2,
    input  logic [DATA_W-1:0] B3,
    input  logic [DATA_W-1:0] HP,
    input  logic [DATA_W-1:0] VOL
);

    localparam int FRAME_W = 16;

    // synchronizers plus one extra delayed copy for edge detection
    logic [SYNC_STG-1:0] ss_s, sclk_s, mosi_s;
    logic                ss_d, sclk_d;

    logic ss_sync, sclk_sync, mosi_sync;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [FRAME_W-1:0] tx_shift, tx_nxt;
    logic [FRAME_W-1:0] rx_shift;
    logic [4:0]         bit_cnt;
    logic               first_fall;
    logic [2:0]         chnnl;
    logic [DATA_W-1:0]  pot_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            // SS_n and SCLK idle high, so preset them to avoid a false edge
            ss_s   <= '1;
            sclk_s <= '1;
            mosi_s <= '0;
            ss_d   <= 1'b1;
            sclk_d <= 1'b1;
        end else begin
            ss_s   <= {ss_s[SYNC_STG-2:0],   SS_n};
            sclk_s <= {sclk_s[SYNC_STG-2:0], SCLK};
            mosi_s <= {mosi_s[SYNC_STG-2:0], MOSI};
            ss_d   <= ss_s[SYNC_STG-1];
            sclk_d <= sclk_s[SYNC_STG-1];
        end
    end

    assign ss_sync   = ss_s[SYNC_STG-1];
    assign sclk_sync = sclk_s[SYNC_STG-1];
    assign mosi_sync = mosi_s[SYNC_STG-1];

    assign ss_fall   =  ss_d   & ~ss_sync;
    assign ss_rise   = ~ss_d   &  ss_sync;
    assign sclk_rise = ~sclk_d &  sclk_sync;
    assign sclk_fall =  sclk_d & ~sclk_sync;

    always_comb begin
        pot_sel = '0;
        case (chnnl)
            3'd0:    pot_sel = B1;
            3'd1:    pot_sel = LP;
            3'd2:    pot_sel = B3;
            3'd3:    pot_sel = HP;
            3'd4:    pot_sel = B2;
            3'd7:    pot_sel = VOL;
            default: pot_sel = '0;
        endcase
    end

    // Next transmit word; MISO is registered from it so the new MSB appears
    // in the same cycle the shift register is loaded or shifted.
    always_comb begin
        tx_nxt = tx_shift;
        if (ss_fall)
            tx_nxt = {{(FRAME_W-DATA_W){1'b0}}, pot_sel};
        else if (!ss_sync && sclk_fall && !first_fall)
            tx_nxt = {tx_shift[FRAME_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            first_fall <= 1'b1;
            chnnl      <= '0;
            MISO       <= 1'b0;
        end else begin
            tx_shift <= tx_nxt;
            MISO     <= ~ss_sync & tx_nxt[FRAME_W-1];
            if (ss_fall) begin
                // SCLK edges coinciding with the select edge are dropped
                bit_cnt    <= '0;
                first_fall <= 1'b1;
            end else if (!ss_sync) begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[FRAME_W-2:0], mosi_sync};
                    if (bit_cnt != 5'd16)
                        bit_cnt <= bit_cnt + 5'd1;
                end
                // the first falling edge only arms shifting so the MSB,
                // already on MISO, is held for the first rising edge
                if (sclk_fall && first_fall)
                    first_fall <= 1'b0;
            end else if (ss_rise && bit_cnt == 5'd16) begin
                // aborted frames (< 16 bits) leave the channel untouched
                chnnl <= rx_shift[13:11];
            end
        end
    end

endmodule

// File: tb/tb_adc_pot_spi_slave.sv
module tb_adc_pot_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] LP  = 12'd1028;
    logic [11:0] B1  = 12'h123;
    logic [11:0] B2  = 12'h789;
    logic [11:0] B3  = 12'h456;
    logic [11:0] HP  = 12'hABC;
    logic [11:0] VOL = 12'd0;

    int n_cmp = 0;
    int n_err = 0;

    adc_pot_spi_slave #(.DATA_W(12), .SYNC_STG(2)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .LP(LP), .B1(B1), .B2(B2), .B3(B3), .HP(HP), .VOL(VOL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;   // command sent in this frame
        logic [11:0] vol;   // VOL pot during this frame
        logic [15:0] exp;   // word expected back (selected by previous cmd)
    } vec_t;

    vec_t vt[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SPI mode-3 style master: MOSI changes on SCLK fall, MISO sampled just
    // before SCLK rise. Half-period 8 clk.
    task automatic frame(input logic [31:0] cmd, input int nbits, output logic [15:0] rd);
        rd = '0;
        SS_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[nbits-1-i];
            tick(8);
            if (i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            tick(8);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(8);
    endtask

    logic [15:0] rd;

    initial begin
        vt[0]  = '{16'h0000, 12'd0,    16'h0123}; // reset channel ch0 = B1
        vt[1]  = '{16'h0800, 12'd0,    16'h0123}; // select ch1
        vt[2]  = '{16'h0000, 12'd0,    16'h0404}; // LP = 1028
        vt[3]  = '{16'h3800, 12'd1000, 16'h0123}; // select ch7
        vt[4]  = '{16'h3800, 12'd1000, 16'h03E8}; // VOL = 1000
        vt[5]  = '{16'h2800, 12'd4095, 16'h0FFF}; // VOL max, select ch5
        vt[6]  = '{16'h1000, 12'd4095, 16'h0000}; // ch5 reads 0, select ch2
        vt[7]  = '{16'h2000, 12'd4095, 16'h0456}; // B3, select ch4
        vt[8]  = '{16'h1800, 12'd4095, 16'h0789}; // B2, select ch3
        vt[9]  = '{16'hC7FF, 12'd4095, 16'h0ABC}; // HP; don't-care bits set, ch0
        vt[10] = '{16'h3000, 12'd4095, 16'h0123}; // B1, select ch6
        vt[11] = '{16'h0000, 12'd4095, 16'h0000}; // ch6 reads 0

        tick(3);
        check("reset_miso", {15'd0, MISO}, 16'h0000);
        rst = 1'b0;
        tick(4);

        for (int k = 0; k < 12; k++) begin
            VOL = vt[k].vol;
            frame({16'h0, vt[k].cmd}, 16, rd);
            check($sformatf("vec%0d", k), rd, vt[k].exp);
        end
        check("idle_miso", {15'd0, MISO}, 16'h0000);

        // aborted frame must not change the channel
        frame(32'h1800, 16, rd);                 // select ch3, reads ch0
        check("abort_sel", rd, 16'h0123);
        frame(32'h20, 8, rd);                    // ch4 command cut after 8 bits
        frame(32'h0, 16, rd);
        check("abort_keep_ch3", rd, 16'h0ABC);

        // 20 rising edges: channel comes from the last 16 bits (ch7)
        VOL = 12'hFFF;
        frame(32'h000F3800, 20, rd);
        check("long_first16", rd, 16'h0123);
        frame(32'h0, 16, rd);
        check("long_ch7", rd, 16'h0FFF);

        // pot change mid-frame does not disturb the loaded word
        fork
            frame(32'h0800, 16, rd);
            begin tick(50); B1 = 12'h555; end
        join
        check("pot_midframe", rd, 16'h0123);
        B1 = 12'h123;
        frame(32'h3800, 16, rd);                 // reads ch1, selects ch7
        check("sel_ch7", rd, 16'h0404);

        // reset pulse mid-frame: MISO cleared, channel back to ch0
        fork
            frame(32'h0, 16, rd);
            begin
                tick(8 + 16*6 + 4);
                check("pre_rst_miso", {15'd0, MISO}, 16'h0001);
                rst = 1'b1;
                tick(1);
                check("post_rst_miso", {15'd0, MISO}, 16'h0000);
                rst = 1'b0;
            end
        join
        frame(32'h0, 16, rd);
        check("after_rst_ch0", rd, 16'h0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
